// File: rtl/ex_multicycle.sv
// Execute stage: single-cycle RV32I ALU/address/jump results plus shift-add multiply and
// restoring divide (XLEN+1 cycles, busy_o high); a finished result waits in HOLD until out_ready.
module ex_multicycle #(
   parameter int XLEN  = 32,
   parameter int OPT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPT_W-1:0] opt_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  rdata1_i,
   input  logic [XLEN-1:0]  rdata2_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic             we_i,
   input  logic [4:0]       waddr_i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  alu_o,
   output logic [XLEN-1:0]  rdata2_o,
   output logic [OPT_W-1:0] opt_o,
   output logic             we_o,
   output logic [4:0]       waddr_o,
   output logic             busy_o
);
   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW:0] LAST = (SHW+1)'(XLEN);

   localparam logic [OPT_W-1:0] OP_ADD    = OPT_W'(1),  OP_SUB   = OPT_W'(2),  OP_SLL   = OPT_W'(3);
   localparam logic [OPT_W-1:0] OP_SLT    = OPT_W'(4),  OP_SLTU  = OPT_W'(5),  OP_XOR   = OPT_W'(6);
   localparam logic [OPT_W-1:0] OP_SRL    = OPT_W'(7),  OP_SRA   = OPT_W'(8),  OP_OR    = OPT_W'(9);
   localparam logic [OPT_W-1:0] OP_AND    = OPT_W'(10), OP_ADDI  = OPT_W'(11), OP_SLTI  = OPT_W'(12);
   localparam logic [OPT_W-1:0] OP_SLTIU  = OPT_W'(13), OP_XORI  = OPT_W'(14), OP_ORI   = OPT_W'(15);
   localparam logic [OPT_W-1:0] OP_ANDI   = OPT_W'(16), OP_SLLI  = OPT_W'(17), OP_SRLI  = OPT_W'(18);
   localparam logic [OPT_W-1:0] OP_SRAI   = OPT_W'(19), OP_LUI   = OPT_W'(20), OP_AUIPC = OPT_W'(21);
   localparam logic [OPT_W-1:0] OP_JAL    = OPT_W'(22), OP_JALR  = OPT_W'(23), OP_LOAD  = OPT_W'(24);
   localparam logic [OPT_W-1:0] OP_STORE  = OPT_W'(25);
   localparam logic [OPT_W-1:0] OP_MUL    = OPT_W'(32), OP_MULH  = OPT_W'(33), OP_MULHSU = OPT_W'(34);
   localparam logic [OPT_W-1:0] OP_MULHU  = OPT_W'(35), OP_DIV   = OPT_W'(36), OP_DIVU  = OPT_W'(37);
   localparam logic [OPT_W-1:0] OP_REM    = OPT_W'(38), OP_REMU  = OPT_W'(39);

   typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;

   state_t            state, state_nxt;
   logic              accept, is_mul, is_div, div_zero, div_ovf, iterate;
   logic              a_sgn, b_sgn, sc_known;
   logic [XLEN-1:0]   a_mag, b_mag, sc_res;
   logic [2*XLEN-1:0] acc, mcand, prod;
   logic [XLEN-1:0]   qmp, quot, remd, fix_res;
   logic [XLEN:0]     rem_sh, rem_diff;
   logic              neg_q, neg_r;
   logic [SHW:0]      cnt;

   assign out_valid = (state == HOLD);
   assign busy_o    = (state == MUL) || (state == DIV);
   assign in_ready  = !rst && !flush_i && ((state == IDLE) || ((state == HOLD) && out_ready));
   assign accept    = in_valid && in_ready;

   always_comb begin
      is_mul   = (opt_i == OP_MUL) || (opt_i == OP_MULH) || (opt_i == OP_MULHSU) || (opt_i == OP_MULHU);
      is_div   = (opt_i == OP_DIV) || (opt_i == OP_DIVU) || (opt_i == OP_REM) || (opt_i == OP_REMU);
      a_sgn    = ((opt_i == OP_MULH) || (opt_i == OP_MULHSU) || (opt_i == OP_DIV) || (opt_i == OP_REM))
                 && rdata1_i[XLEN-1];
      b_sgn    = ((opt_i == OP_MULH) || (opt_i == OP_DIV) || (opt_i == OP_REM)) && rdata2_i[XLEN-1];
      a_mag    = a_sgn ? -rdata1_i : rdata1_i;
      b_mag    = b_sgn ? -rdata2_i : rdata2_i;
      div_zero = is_div && (rdata2_i == '0);
      div_ovf  = ((opt_i == OP_DIV) || (opt_i == OP_REM)) && (rdata1_i == {1'b1, {(XLEN-1){1'b0}}})
                 && (rdata2_i == '1);
      // Zero divisor and signed overflow have fixed answers, so they skip the iterative unit.
      iterate  = is_mul || (is_div && !div_zero && !div_ovf);
   end

   always_comb begin
      sc_res   = '0;
      sc_known = 1'b1;
      case (opt_i)
         OP_ADD:   sc_res = rdata1_i + rdata2_i;
         OP_SUB:   sc_res = rdata1_i - rdata2_i;
         OP_SLL:   sc_res = rdata1_i << rdata2_i[SHW-1:0];
         OP_SLT:   sc_res = {{(XLEN-1){1'b0}}, $signed(rdata1_i) < $signed(rdata2_i)};
         OP_SLTU:  sc_res = {{(XLEN-1){1'b0}}, rdata1_i < rdata2_i};
         OP_XOR:   sc_res = rdata1_i ^ rdata2_i;
         OP_SRL:   sc_res = rdata1_i >> rdata2_i[SHW-1:0];
         OP_SRA:   sc_res = $unsigned($signed(rdata1_i) >>> rdata2_i[SHW-1:0]);
         OP_OR:    sc_res = rdata1_i | rdata2_i;
         OP_AND:   sc_res = rdata1_i & rdata2_i;
         OP_ADDI, OP_LOAD, OP_STORE: sc_res = rdata1_i + imm_i;
         OP_SLTI:  sc_res = {{(XLEN-1){1'b0}}, $signed(rdata1_i) < $signed(imm_i)};
         OP_SLTIU: sc_res = {{(XLEN-1){1'b0}}, rdata1_i < imm_i};
         OP_XORI:  sc_res = rdata1_i ^ imm_i;
         OP_ORI:   sc_res = rdata1_i | imm_i;
         OP_ANDI:  sc_res = rdata1_i & imm_i;
         OP_SLLI:  sc_res = rdata1_i << imm_i[SHW-1:0];
         OP_SRLI:  sc_res = rdata1_i >> imm_i[SHW-1:0];
         OP_SRAI:  sc_res = $unsigned($signed(rdata1_i) >>> imm_i[SHW-1:0]);
         OP_LUI:   sc_res = imm_i;
         OP_AUIPC: sc_res = pc_i + imm_i;
         OP_JAL, OP_JALR: sc_res = pc_i + XLEN'(4);
         OP_DIV, OP_DIVU: sc_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
         OP_REM, OP_REMU: sc_res = div_zero ? rdata1_i : '0;
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: sc_res = '0;
         default:  sc_known = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = IDLE;
      end else if (accept) begin
         state_nxt = !iterate ? HOLD : (is_mul ? MUL : DIV);
      end else begin
         case (state)
            MUL, DIV: if (cnt == LAST) state_nxt = HOLD;
            HOLD:     if (out_ready) state_nxt = IDLE;
            default:  state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Restoring divide step: remainder in acc[XLEN:0], dividend bits shift out of qmp as quotient bits shift in.
   assign rem_sh   = {acc[XLEN-1:0], qmp[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, mcand[XLEN-1:0]};

   always_comb begin
      prod    = neg_q ? -acc : acc;
      quot    = neg_q ? -qmp : qmp;
      remd    = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      fix_res = '0;
      if (state == MUL) fix_res = (opt_o == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else              fix_res = ((opt_o == OP_DIV) || (opt_o == OP_DIVU)) ? quot : remd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_o    <= '0;
         rdata2_o <= '0;
         opt_o    <= '0;
         we_o     <= 1'b0;
         waddr_o  <= '0;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         qmp      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
      end else if (accept) begin
         rdata2_o <= rdata2_i;
         opt_o    <= opt_i;
         we_o     <= we_i && sc_known;
         waddr_o  <= waddr_i;
         cnt      <= '0;
         acc      <= '0;
         qmp      <= a_mag;
         mcand    <= {{XLEN{1'b0}}, b_mag};
         neg_q    <= a_sgn ^ b_sgn;
         neg_r    <= a_sgn;
         if (!iterate) alu_o <= sc_res;
      end else if (busy_o && !flush_i) begin
         if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
            if (state == MUL) begin
               if (qmp[0]) acc <= acc + mcand;
               mcand <= mcand << 1;
               qmp   <= qmp >> 1;
            end else if (!rem_diff[XLEN]) begin
               acc <= {{(XLEN-1){1'b0}}, rem_diff};
               qmp <= {qmp[XLEN-2:0], 1'b1};
            end else begin
               acc <= {{(XLEN-1){1'b0}}, rem_sh};
               qmp <= {qmp[XLEN-2:0], 1'b0};
            end
         end else begin
            alu_o <= fix_res;
         end
      end
   end
endmodule

// File: tb/tb_ex_multicycle.sv
// Directed and random checks of ex_multicycle against an arithmetic reference model.
// Latency is counted in clock edges after the accept edge until out_valid is seen (0 = single-cycle).
module tb_ex_multicycle;
   localparam int XLEN = 32;
   localparam int OPT_W = 6;

   localparam logic [5:0] OP_ADD = 1, OP_SUB = 2, OP_SLL = 3, OP_SLT = 4, OP_SLTU = 5, OP_XOR = 6;
   localparam logic [5:0] OP_SRL = 7, OP_SRA = 8, OP_OR = 9, OP_AND = 10, OP_ADDI = 11, OP_SLTI = 12;
   localparam logic [5:0] OP_SLTIU = 13, OP_XORI = 14, OP_ORI = 15, OP_ANDI = 16, OP_SLLI = 17;
   localparam logic [5:0] OP_SRLI = 18, OP_SRAI = 19, OP_LUI = 20, OP_AUIPC = 21, OP_JAL = 22;
   localparam logic [5:0] OP_JALR = 23, OP_LOAD = 24, OP_STORE = 25;
   localparam logic [5:0] OP_MUL = 32, OP_MULH = 33, OP_MULHSU = 34, OP_MULHU = 35;
   localparam logic [5:0] OP_DIV = 36, OP_DIVU = 37, OP_REM = 38, OP_REMU = 39;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst, flush_i, in_valid, in_ready, we_i, out_valid, out_ready, we_o, busy_o;
   logic [5:0]  opt_i, opt_o;
   logic [31:0] pc_i, rdata1_i, rdata2_i, imm_i, alu_o, rdata2_o;
   logic [4:0]  waddr_i, waddr_o;

   int total = 0;
   int bad = 0;

   logic [5:0] sc_ops[$]  = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR,
                              OP_AND, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI,
                              OP_SRLI, OP_SRAI, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_STORE};
   logic [5:0] all_ops[$] = '{OP_ADD, OP_SUB, OP_SRA, OP_SLTU, OP_JALR, OP_AUIPC, 6'd0, 6'd63,
                              OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

   always #5 clk = ~clk;

   ex_multicycle #(.XLEN(XLEN), .OPT_W(OPT_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid(in_valid), .in_ready(in_ready),
      .opt_i(opt_i), .pc_i(pc_i), .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .imm_i(imm_i),
      .we_i(we_i), .waddr_i(waddr_i), .out_valid(out_valid), .out_ready(out_ready),
      .alu_o(alu_o), .rdata2_o(rdata2_o), .opt_o(opt_o), .we_o(we_o), .waddr_o(waddr_o),
      .busy_o(busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                                         output logic known, output int edges);
      int sa, sb;
      longint la, lb;
      logic [63:0] p;
      sa = a; sb = b; la = sa; lb = sb;
      known = 1'b1; edges = 0;
      case (op)
         OP_ADD:   return a + b;
         OP_SUB:   return a - b;
         OP_SLL:   return a << b[4:0];
         OP_SLT:   return {31'd0, sa < sb};
         OP_SLTU:  return {31'd0, a < b};
         OP_XOR:   return a ^ b;
         OP_SRL:   return a >> b[4:0];
         OP_SRA:   return 32'($signed(a) >>> b[4:0]);
         OP_OR:    return a | b;
         OP_AND:   return a & b;
         OP_ADDI, OP_LOAD, OP_STORE: return a + imm;
         OP_SLTI:  return {31'd0, sa < $signed(imm)};
         OP_SLTIU: return {31'd0, a < imm};
         OP_XORI:  return a ^ imm;
         OP_ORI:   return a | imm;
         OP_ANDI:  return a & imm;
         OP_SLLI:  return a << imm[4:0];
         OP_SRLI:  return a >> imm[4:0];
         OP_SRAI:  return 32'($signed(a) >>> imm[4:0]);
         OP_LUI:   return imm;
         OP_AUIPC: return pc + imm;
         OP_JAL, OP_JALR: return pc + 32'd4;
         OP_MUL:    begin edges = XLEN + 1; p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         OP_MULH:   begin edges = XLEN + 1; p = la * lb; return p[63:32]; end
         OP_MULHSU: begin edges = XLEN + 1; p = la * longint'({32'd0, b}); return p[63:32]; end
         OP_MULHU:  begin edges = XLEN + 1; p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
            edges = XLEN + 1; return 32'(sa / sb);
         end
         OP_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            edges = XLEN + 1; return a / b;
         end
         OP_REM: begin
            if (b == 0) return a;
            if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
            edges = XLEN + 1; return 32'(sa % sb);
         end
         OP_REMU: begin
            if (b == 0) return a;
            edges = XLEN + 1; return a % b;
         end
         default: begin known = 1'b0; return 32'd0; end
      endcase
   endfunction

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return MINV;
         default: return $urandom;
      endcase
   endfunction

   // Issue one request from IDLE with out_ready high; inputs are scrambled while it runs.
   task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a, b, imm, pc);
      logic [31:0] exp;
      logic known, we;
      logic [4:0] wa;
      int edges, n, busy_n;
      exp = model(op, a, b, imm, pc, known, edges);
      we = 1'($urandom); wa = 5'($urandom);
      opt_i = op; rdata1_i = a; rdata2_i = b; imm_i = imm; pc_i = pc;
      we_i = we; waddr_i = wa; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk({tag, " in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; n = 0; busy_n = 0;
      while (!out_valid && n < 200) begin
         busy_n += int'(busy_o);
         rdata1_i = $urandom; rdata2_i = $urandom; opt_i = 6'($urandom);
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, n, edges);
      chk({tag, " busy cycles"}, busy_n, edges);
      chk({tag, " alu_o"}, alu_o, exp);
      chk({tag, " we_o"}, we_o, we & known);
      chk({tag, " waddr_o"}, waddr_o, wa);
      chk({tag, " rdata2_o"}, rdata2_o, b);
      chk({tag, " opt_o"}, opt_o, op);
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] exp, a, b, imm, pc;
      logic [5:0] op;
      logic known;
      int edges, n;

      rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opt_i = '0; pc_i = '0;
      rdata1_i = '0; rdata2_i = '0; imm_i = '0; we_i = 1'b0; waddr_i = '0;
      @(negedge clk);
      chk("reset in_ready", in_ready, 0);
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset busy", busy_o, 0);
      chk("reset alu_o", alu_o, 0);
      chk("reset side", {rdata2_o, opt_o, we_o, waddr_o}, 0);
      rst = 1'b0;
      #1 chk("idle in_ready", in_ready, 1);

      run_op("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 0, 0);
      run_op("mulh", OP_MULH, -32'sd2, 32'd3, 0, 0);
      run_op("div ovf", OP_DIV, MINV, 32'hFFFF_FFFF, 0, 0);
      run_op("rem ovf", OP_REM, MINV, 32'hFFFF_FFFF, 0, 0);
      run_op("divu zero", OP_DIVU, 32'd7, 32'd0, 0, 0);
      run_op("rem by zero", OP_REM, -32'sd9, 32'd0, 0, 0);
      run_op("jal", OP_JAL, $urandom, $urandom, $urandom, 32'h100);
      run_op("lui", OP_LUI, $urandom, $urandom, 32'hABCDE000, 0);
      run_op("sra", OP_SRA, MINV, 32'h24, 0, 0);
      run_op("undefined", 6'd50, 32'd5, 32'd6, 0, 0);

      // REM stalled in HOLD while a new ADD waits at the input
      opt_i = OP_REM; rdata1_i = -32'sd7; rdata2_i = 32'd2; we_i = 1'b1; waddr_i = 5'd9;
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      opt_i = OP_ADD; rdata1_i = 32'd10; rdata2_i = 32'd20; waddr_i = 5'd3;
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      chk("rem stall latency", n, 33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall out_valid", out_valid, 1);
         chk("stall alu_o", alu_o, 32'hFFFF_FFFF);
         chk("stall side", {opt_o, waddr_o}, {OP_REM, 5'd9});
         chk("stall in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1 chk("release in_ready", in_ready, 1);
      @(negedge clk);
      chk("hold2hold out_valid", out_valid, 1);
      chk("hold2hold alu_o", alu_o, 32'd30);
      chk("hold2hold opt_o", opt_o, OP_ADD);

      // Back-to-back single-cycle ops, one per cycle
      for (int i = 0; i < 8; i++) begin
         op = sc_ops[$urandom_range(0, sc_ops.size() - 1)];
         a = rnd_val(); b = rnd_val(); imm = rnd_val(); pc = $urandom;
         exp = model(op, a, b, imm, pc, known, edges);
         opt_i = op; rdata1_i = a; rdata2_i = b; imm_i = imm; pc_i = pc;
         @(negedge clk);
         chk("b2b out_valid", out_valid, 1);
         chk("b2b alu_o", alu_o, exp);
      end

      // Multiply accepted in the cycle the previous result leaves
      a = rnd_val(); b = rnd_val();
      exp = model(OP_MULHSU, a, b, 0, 0, known, edges);
      opt_i = OP_MULHSU; rdata1_i = a; rdata2_i = b;
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold2mul drop", out_valid, 0);
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      chk("hold2mul latency", n, 33);
      chk("hold2mul alu_o", alu_o, exp);
      @(negedge clk);

      // Flush ten cycles into a DIVU with another request presented
      opt_i = OP_DIVU; rdata1_i = 32'd1000; rdata2_i = 32'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      flush_i = 1'b1; in_valid = 1'b1; opt_i = OP_SUB;
      #1 chk("flush in_ready", in_ready, 0);
      @(negedge clk);
      flush_i = 1'b0; in_valid = 1'b0;
      chk("flush out_valid", out_valid, 0);
      chk("flush busy", busy_o, 0);
      run_op("post flush add", OP_ADD, 32'd40, 32'd2, 0, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); n += int'(out_valid); end
      chk("flush no result", n, 0);

      // Reset in the middle of a multiply
      opt_i = OP_MUL; rdata1_i = 32'd12345; rdata2_i = 32'd678; we_i = 1'b1; waddr_i = 5'd7;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1 chk("rst mid in_ready", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst mid out_valid", out_valid, 0);
      chk("rst mid busy", busy_o, 0);
      chk("rst mid outputs", {alu_o, rdata2_o, opt_o, we_o, waddr_o}, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin @(negedge clk); n += int'(out_valid); end
      chk("rst mid no result", n, 0);

      for (int i = 0; i < 30; i++) begin
         op = all_ops[$urandom_range(0, all_ops.size() - 1)];
         run_op("random", op, rnd_val(), rnd_val(), rnd_val(), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex_multicycle.md
EX_MULTICYCLE -- requirements
Module: ex_multicycle

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- XLEN, 32, datapath width; legal values 32 or 64.
- OPT_W, 6, width of the operation code.
- SHW, log2(XLEN), shift-amount width; derived, not overridable.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, rising-edge clock.
- rst, in, 1, reset; synchronous, active-high.
- flush_i, in, 1, aborts the in-flight operation and discards the pending result.
- in_valid, in, 1, request present.
- in_ready, out, 1, request accepted when in_valid and in_ready are both high.
- opt_i, in, OPT_W, operation: RV32I ALU, load/store address, and LUI/AUIPC/JAL/JALR codes, plus MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- pc_i, in, XLEN, instruction PC.
- rdata1_i, in, XLEN, rs1 value.
- rdata2_i, in, XLEN, rs2 value.
- imm_i, in, XLEN, sign-extended immediate.
- we_i, in, 1, register write enable.
- waddr_i, in, 5, destination register.
- out_valid, out, 1, result present.
- out_ready, in, 1, downstream accepts the result.
- alu_o, out, XLEN, result.
- rdata2_o, out, XLEN, rs2 passthrough for stores.
- opt_o, out, OPT_W, operation passthrough.
- we_o, out, 1, write enable passthrough.
- waddr_o, out, 5, destination passthrough.
- busy_o, out, 1, high while an iterative operation is running.

Function
REQ-003 The FSM SHALL have states IDLE, MUL, DIV and HOLD; HOLD means a result is waiting for out_ready.
REQ-004 in_ready SHALL be high only when the state is IDLE, or when the state is HOLD and out_ready is high.
REQ-005 Single-cycle ops SHALL load the outputs on the accept edge, assert out_valid on the next cycle, and enter HOLD.
- Single-cycle ops are ALU, address, LUI, AUIPC, JAL and JALR.
- Results match RV32I semantics at width XLEN; JAL and JALR return pc_i+4.
- Register shifts use rdata2_i[SHW-1:0].
REQ-006 Throughput: back-to-back single-cycle ops with out_ready held high SHALL complete one per cycle.
REQ-007 MUL-family ops SHALL use a shift-add multiplier with a 2*XLEN-bit product.
- The unit iterates for XLEN cycles, then spends 1 cycle on sign fix-up.
- out_valid rises exactly XLEN+1 cycles after the accept edge.
REQ-008 MUL SHALL return the low XLEN bits of the product. MULH, MULHSU and MULHU SHALL return the high XLEN bits, with operands signed×signed, signed×unsigned and unsigned×unsigned respectively.
REQ-009 DIV-family ops SHALL use a restoring divider on operand magnitudes.
- The divider runs for XLEN iterations plus 1 sign-correction cycle, giving XLEN+1 cycles of latency.
- The quotient is rounded toward zero; the remainder takes the sign of the dividend.
REQ-010 A divisor of 0 SHALL take the single-cycle path.
- Quotient result: all ones.
- Remainder result: the dividend.
REQ-011 Signed overflow (dividend -2^(XLEN-1), divisor -1) SHALL take the single-cycle path.
- Quotient result: -2^(XLEN-1).
- Remainder result: 0.
REQ-012 busy_o SHALL be high exactly while the state is MUL or DIV.
REQ-013 Operands SHALL be latched on accept, so changes on the inputs during iteration have no effect.
REQ-014 In HOLD with out_ready low, all outputs SHALL stay stable and in_ready SHALL stay low.
REQ-015 A HOLD→MUL/DIV transition (accept in the same cycle the old result is consumed) SHALL drop out_valid the next cycle.
REQ-016 A HOLD→HOLD transition (a single-cycle op accepted in the same cycle) SHALL keep out_valid high and present the new result.
REQ-017 flush_i SHALL take priority over all other inputs.
- On the next edge: state goes to IDLE and out_valid goes to 0.
- Any iteration is abandoned.
- A request presented in the flush cycle is not accepted, and in_ready is forced low in that cycle.
REQ-018 An undefined opt_i SHALL be handled as a single-cycle op with alu_o=0 and we_o=0.
REQ-019 rdata2_o, opt_o, we_o and waddr_o SHALL carry the accepted request's values for as long as out_valid is high.

Reset
REQ-020 While rst is high, on the clock edge:
- State goes to IDLE; out_valid and busy_o go to 0.
- alu_o, rdata2_o, opt_o, waddr_o and we_o go to 0.
- in_ready reads 0 during the cycle rst is high.
REQ-021 Reset asserted mid-iteration or in HOLD SHALL discard the operation, with no result emitted afterwards.

Verification
REQ-022 ADD with 0x7FFFFFFF + 0x1 and out_ready=1 -> out_valid one cycle later, alu_o=0x80000000.
REQ-023 MULH with -2 × 3 (XLEN=32) -> out_valid exactly 33 cycles after accept, alu_o=0xFFFFFFFF; busy_o high for 33 cycles.
REQ-024 DIV with 0x80000000 / 0xFFFFFFFF -> alu_o=0x80000000 after 1 cycle; REM with the same operands -> 0; DIVU with 7/0 -> 0xFFFFFFFF after 1 cycle.
REQ-025 REM with -7 / 2 -> alu_o=0xFFFFFFFF after 33 cycles; hold out_ready low for 5 cycles -> outputs stable and in_ready low throughout.
REQ-026 flush_i pulsed 10 cycles into a DIVU with in_valid also high -> no out_valid, request not accepted; a new ADD issued next cycle completes with out_valid one cycle after its accept.
REQ-027 rst asserted mid-MUL -> all outputs 0 the next cycle, and no result ever appears for that MUL.
